// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: execute-stage <-> HI/LO mul/div unit bus.
//   master : execute stage (drives Start/Op/A/B and MTHI/MTLO strobes)
//   slave  : hilo_muldiv_unit (drives Busy/Done and the HI/LO registers)
//   Start/Op/A/B        : operation request, sampled only while Busy=0
//   WriteHi/WriteLo     : MTHI/MTLO strobes, data on WriteData
//   Busy/Done           : in-flight flag / one-cycle result pulse
//   HiReg_output/LoReg_output : architectural HI/LO
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             WriteHi;
  logic             WriteLo;
  logic [WIDTH-1:0] WriteData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HiReg_output;
  logic [WIDTH-1:0] LoReg_output;

  modport master (
    output Start, Op, A, B, WriteHi, WriteLo, WriteData,
    input  Busy, Done, HiReg_output, LoReg_output
  );

  modport slave (
    input  Start, Op, A, B, WriteHi, WriteLo, WriteData,
    output Busy, Done, HiReg_output, LoReg_output
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
//   Clk : clock, rising edge
//   Rst : asynchronous active-high reset (aborts any op, clears HI/LO)
//   bus : hilo_muldiv_if.slave -- request, MTHI/MTLO, Busy/Done, HI/LO
// One bit per cycle over WIDTH RUN cycles, then one FIX cycle applies signs
// and writes HI/LO. Busy is high for WIDTH+1 cycles; Done pulses with result.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  hilo_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             busy, done;
  logic [WIDTH-1:0] hi_q, lo_q;
  // Shared accumulator: multiply {partial product, multiplier},
  // divide {remainder, dividend shifting into quotient}.
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opnd;          // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_q;         // product / quotient sign
  logic             neg_r;         // remainder sign (dividend sign)

  // Request decode and operand magnitudes
  logic             signed_op, div_op, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = ~bus.Op[0];
    div_op    = bus.Op[1];
    b_zero    = (bus.B == '0);
    a_mag     = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // Iteration step datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_part = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opnd});
    div_diff = div_part - {1'b0, opnd};
    prod     = {acc_hi, acc_lo};
    prod_neg = -prod;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // MT writes land now even if a Start is accepted on the same edge;
          // the op result overwrites them at FIX.
          if (bus.WriteHi) hi_q <= bus.WriteData;
          if (bus.WriteLo) lo_q <= bus.WriteData;
          if (bus.Start) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= div_op;
            acc_hi <= '0;
            acc_lo <= div_op ? a_mag : b_mag;
            opnd   <= div_op ? b_mag : a_mag;
            // Divide-by-zero: unsigned all-ones quotient must not be negated;
            // remainder path then reproduces the original A.
            neg_q  <= signed_op & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1])
                      & ~(div_op & b_zero);
            neg_r  <= signed_op & bus.A[WIDTH-1];
          end
        end
        RUN: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo_q <= neg_q ? -acc_lo : acc_lo;
            hi_q <= neg_r ? -acc_hi : acc_hi;
          end else begin
            {hi_q, lo_q} <= neg_q ? prod_neg : prod;
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy         = busy;
  assign bus.Done         = done;
  assign bus.HiReg_output = hi_q;
  assign bus.LoReg_output = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  // Reference model using native SV arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sp;
    logic [63:0] up;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r.hi = sp[63:32]; r.lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32]; r.lo = up[31:0];
      end
      2'b10: begin
        if (b == 0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r.lo = 32'h80000000; r.hi = 0; end
        else begin
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  // Called at a negedge; Start sampled on the next posedge (edge 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.hi = ehi; e.lo = elo;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    sb.push_back(e);
    @(negedge clk);
    bus.Start = 1'b0;
    checks++;
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", bus.Busy); end
    checks++;
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_low_at_start: got %b want 0", bus.Done); end
  endtask

  // Waits for Done, checks busy length and pops scoreboard. Ends on the Done negedge.
  task automatic wait_result(input string name, input int busy_seen);
    int   busy_n = busy_seen;
    int   guard  = 0;
    exp_t e;
    while (bus.Done !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (bus.Busy === 1'b1) busy_n++;
    end
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s sb_empty: no expected result queued", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: Done not seen within %0d cycles", name, guard);
      return;
    end
    checks++;
    if (busy_n != 33) begin errors++; $display("FAIL %s busy_len: got %0d want 33", name, busy_n); end
    checks++;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL %s busy_fall: got %b want 0", name, bus.Busy); end
    checks++;
    if (bus.HiReg_output !== e.hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, bus.HiReg_output, e.hi); end
    checks++;
    if (bus.LoReg_output !== e.lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, bus.LoReg_output, e.lo); end
    cur_hi = e.hi; cur_lo = e.lo;
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, bus.Done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Start = 0; bus.Op = 0; bus.A = 0; bus.B = 0;
    bus.WriteHi = 0; bus.WriteLo = 0; bus.WriteData = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.Busy, bus.Done}); end
    checks++;
    if ({bus.HiReg_output, bus.LoReg_output} !== 64'd0) begin
      errors++; $display("FAIL reset_hilo: got %h want 0", {bus.HiReg_output, bus.LoReg_output});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_result("mult_neg3x7", 1);
    check_done_pulse("mult_neg3x7");
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_result("multu_max", 1);
    check_done_pulse("multu_max");
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    wait_result("mult_m1xm1", 1);
    check_done_pulse("mult_m1xm1");
  endtask

  task automatic test_div();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_result("div_neg7by2", 1);
    check_done_pulse("div_neg7by2");
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    wait_result("div_overflow", 1);
    check_done_pulse("div_overflow");
    issue(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
    wait_result("divu_by0", 1);
    check_done_pulse("divu_by0");
    issue(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    wait_result("div_neg_by0", 1);
    check_done_pulse("div_neg_by0");
  endtask

  task automatic test_mt_busy();
    // MTHI in IDLE
    bus.WriteHi = 1'b1; bus.WriteData = 32'h12345678;
    @(negedge clk);
    bus.WriteHi = 1'b0;
    checks++;
    if (bus.HiReg_output !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h want 12345678", bus.HiReg_output); end
    checks++;
    if (bus.LoReg_output !== cur_lo) begin errors++; $display("FAIL mthi_lo_kept: got %h want %h", bus.LoReg_output, cur_lo); end
    cur_hi = 32'h12345678;
    // MTLO in IDLE
    bus.WriteLo = 1'b1; bus.WriteData = 32'h0BADF00D;
    @(negedge clk);
    bus.WriteLo = 1'b0;
    checks++;
    if (bus.LoReg_output !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo: got %h want 0badf00d", bus.LoReg_output); end
    cur_lo = 32'h0BADF00D;
    // MTLO + new Start while busy: both ignored
    issue(2'b01, 32'd1000, 32'd3000, 32'd0, 32'd3000000);
    for (int i = 0; i < 5; i++) @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b11; bus.A = 32'd9; bus.B = 32'd2;
    bus.WriteLo = 1'b1; bus.WriteData = 32'hDEADBEEF;
    @(negedge clk);
    bus.Start = 1'b0; bus.WriteLo = 1'b0;
    checks++;
    if (bus.LoReg_output !== cur_lo) begin errors++; $display("FAIL mtlo_busy_ignored: got %h want %h", bus.LoReg_output, cur_lo); end
    checks++;
    if (bus.HiReg_output !== cur_hi) begin errors++; $display("FAIL hi_stable_busy: got %h want %h", bus.HiReg_output, cur_hi); end
    wait_result("multu_with_ignored", 7);
    check_done_pulse("multu_with_ignored");
    checks++;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL no_queued_start: got busy %b want 0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [1:0]  op;
    logic [31:0] a, b;
    @(negedge clk);
    // Start together with MTHI in IDLE: write lands now, result replaces it.
    bus.WriteHi = 1'b1; bus.WriteData = 32'hCAFEF00D;
    e = model(2'b00, 32'd12345, 32'hFFFF0000);
    issue(2'b00, 32'd12345, 32'hFFFF0000, e.hi, e.lo);
    bus.WriteHi = 1'b0;
    checks++;
    if (bus.HiReg_output !== 32'hCAFEF00D) begin errors++; $display("FAIL start_with_mthi: got %h want cafef00d", bus.HiReg_output); end
    wait_result("b2b_0", 1);
    for (int k = 1; k <= 6; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = (k == 3) ? 32'd0 : $urandom();
      if (k == 5) b = {28'd0, 4'($urandom_range(1, 15))};
      e = model(op, a, b);
      issue(op, a, b, e.hi, e.lo);   // issued on the Done cycle: next edge accepts
      wait_result($sformatf("b2b_%0d_op%0d", k, op), 1);
    end
    check_done_pulse("b2b_last");
  endtask

  task automatic test_abort();
    exp_t e;
    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd25);
    sb.delete();   // reset will discard this op
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.Busy); end
    checks++;
    if ({bus.HiReg_output, bus.LoReg_output} !== 64'd0) begin
      errors++; $display("FAIL abort_hilo: got %h want 0", {bus.HiReg_output, bus.LoReg_output});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.Done !== 1'b0) begin errors++; $display("FAIL abort_no_done_rst: got %b want 0", bus.Done); end
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_done_after: done %b busy %b want 0 0", bus.Done, bus.Busy);
      end
    end
    checks++;
    e = model(2'b11, 32'd10, 32'd3);
    issue(2'b11, 32'd10, 32'd3, 32'd1, 32'd3);
    wait_result("divu_after_abort", 1);
    checks++;
    if (e.lo !== bus.LoReg_output) begin errors++; $display("FAIL model_divu: got %h want %h", bus.LoReg_output, e.lo); end
    check_done_pulse("divu_after_abort");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_busy();
    test_back_to_back();
    test_abort();
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
